// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: program-memory read channel, decoder issue channel and status.
// master = fetch FSM side, slave = memory/decoder/controller side.
interface instr_fetch_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd_en;
    logic [6:0]        imem_data;
    logic              imem_valid;
    logic              stall;
    logic [2:0]        opcode;
    logic [1:0]        operand1;
    logic [1:0]        operand2;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halt;

    modport master (
        input  start, imem_data, imem_valid, stall,
        output imem_addr, imem_rd_en, opcode, operand1, operand2,
               instr_valid, pc, busy, halt
    );

    modport slave (
        output start, imem_data, imem_valid, stall,
        input  imem_addr, imem_rd_en, opcode, operand1, operand2,
               instr_valid, pc, busy, halt
    );
endinterface

// File: rtl/instr_fetch_fsm.sv
// Instruction fetch FSM: IDLE -> FETCH -> ISSUE -> ... -> HALT, pc runs 0..LAST_ADDR.
// Optional macro IFETCH_SKIP_NOP_EN: opcode 3'b000 words are consumed in FETCH, never issued.
module instr_fetch_fsm #(
    parameter int ADDR_W    = 4,
    parameter int LAST_ADDR = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(LAST_ADDR);

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [2:0]        opcode_reg, opcode_next;
    logic [1:0]        operand1_reg, operand1_next;
    logic [1:0]        operand2_reg, operand2_next;
    logic              fetch_is_nop;
    logic              at_last;

`ifdef IFETCH_SKIP_NOP_EN
    assign fetch_is_nop = (bus.imem_data[6:4] == 3'b000);
`else
    assign fetch_is_nop = 1'b0;
`endif

    assign at_last = (pc_reg == PC_LAST);

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        opcode_next   = opcode_reg;
        operand1_next = operand1_reg;
        operand2_next = operand2_reg;
        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.imem_valid) begin
                    if (fetch_is_nop) begin
                        // Skipped word is consumed on the spot, same end-of-program rule as ISSUE.
                        if (at_last) begin
                            state_next = ST_HALT;
                        end else begin
                            pc_next    = pc_reg + 1'b1;
                            state_next = ST_FETCH;
                        end
                    end else begin
                        opcode_next   = bus.imem_data[6:4];
                        operand1_next = bus.imem_data[3:2];
                        operand2_next = bus.imem_data[1:0];
                        state_next    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!bus.stall) begin
                    if (at_last) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            opcode_reg   <= '0;
            operand1_reg <= '0;
            operand2_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            opcode_reg   <= opcode_next;
            operand1_reg <= operand1_next;
            operand2_reg <= operand2_next;
        end
    end

    // Status and handshake outputs decode straight from the state register.
    assign bus.imem_rd_en  = (state_reg == ST_FETCH);
    assign bus.imem_addr   = pc_reg;
    assign bus.instr_valid = (state_reg == ST_ISSUE);
    assign bus.busy        = (state_reg == ST_FETCH) || (state_reg == ST_ISSUE);
    assign bus.halt        = (state_reg == ST_HALT);
    assign bus.pc          = pc_reg;
    assign bus.opcode      = opcode_reg;
    assign bus.operand1    = operand1_reg;
    assign bus.operand2    = operand2_reg;
endmodule
